rr_multi_selector: RTL
======================

Name: rr_multi_selector

Overview:
- Parametrised rotating-priority selector for the issue/dispatch stage of the 2-way superscalar core.
- Each cycle it picks up to W distinct requesters out of N, in circular order starting at an internal round-robin pointer.
- The pointer is a registered state element that advances past the last granted requester, giving fairness without an external counter.
- It generalises the fixed 2/4/8-input rotating selectors to arbitrary N, multiple grant slots and a hold (enable) input.

Parameters:
- N, 8, number of requesters (N >= 2, need not be a power of two)
- W, 2, grants per cycle (1 <= W <= N)
- IDX_W, $clog2(N), width of an encoded requester index (derived, not overridden)
- AGE_MAX, 15, saturation/boost threshold for the optional age feature (AGE_MAX >= 1)

Ports:
- clock, input, 1, single clock; all state changes on its rising edge
- reset_n, input, 1, asynchronous, active-low reset
- en, input, 1, selection enable; 0 = stall, no grants issued
- req, input, N, request vector; bit i = requester i ready
- gnt_bus, output, W*N, one-hot grant per slot; slot s occupies bits [s*N +: N]
- gnt_idx, output, W*IDX_W, encoded index per slot; slot s occupies bits [s*IDX_W +: IDX_W]
- gnt_valid, output, W, slot s holds a valid grant
- gnt_any, output, N, OR of all slot grants
- ptr_out, output, IDX_W, current round-robin pointer

Behaviour:
- Outputs are combinational from req, en and the registered state, so grants have zero-cycle latency. State updates at the next rising clock edge.
- Search order: ptr, ptr+1, ..., N-1, 0, ..., ptr-1, with wrap done modulo N (not modulo 2^IDX_W).
- The k-th requesting bit met in search order goes to slot k-1, for k <= W. Slots beyond the number of requesters have gnt_valid=0, gnt_bus slice=0 and gnt_idx slice=0.
- Slot 0 always holds the highest-priority grant. No requester is granted in two slots.
- en=0: every gnt_bus, gnt_valid and gnt_any bit is 0; the pointer holds.
- en=1 with at least one grant: next ptr = (index of the last valid slot's grant + 1) mod N.
- en=1 with req=0: pointer holds.
- Reset (reset_n=0, async): ptr=0 immediately. While reset_n=0, gnt_bus, gnt_idx, gnt_valid and gnt_any are all forced to 0 and ptr_out=0.
- Reset released mid-operation: the first selection starts from ptr=0.
- Bits of req at index >= N do not exist. ptr never holds a value >= N.
- Invariants, checked by assertions: gnt_bus is a subset of req; each slot is one-hot or zero; gnt_valid is thermometer-coded (slot s valid implies slot s-1 valid); popcount(gnt_any) = popcount(gnt_valid) = min(W, popcount(req)) when en=1.

Optional Feature:
- Macro: RR_SEL_AGE_BOOST_EN.
- Defined:
  - Each requester has a saturating wait counter of width $clog2(AGE_MAX+1), reset to 0.
  - A counter increments when en=1, its req bit is 1 and it is not granted this cycle. It clears when granted or when its req bit is 0. It holds when en=0.
  - When any counter equals AGE_MAX and en=1, the lowest-index such requester is forced into slot 0. Slots 1..W-1 are then filled by normal rotation, skipping that requester.
  - Pointer update uses only the rotation-filled slots. If only the boosted grant exists, ptr holds.
- Undefined: no counters, no boost logic; behaviour is pure rotation as above.

Test Plan:
- Reset: drive reset_n=0 asynchronously between clock edges with req=8'hFF, en=1 -> ptr_out=0 and gnt_valid=2'b00 immediately; after release the first grants are idx0 and idx1.
- Steady full load: N=8, W=2, req=8'hFF, en=1, 4 cycles -> grant pairs (0,1), (2,3), (4,5), (6,7); ptr_out sequence 0, 2, 4, 6, 0.
- Wrap-around: ptr=6, req=8'b0100_0001 -> slot0 idx6, slot1 idx0, gnt_any=8'b0100_0001; next ptr=1.
- Sparse / stall: ptr=1, req=8'b0001_0000 -> slot0 idx4, gnt_valid=2'b01, next ptr=5. Then en=0 with req=8'hFF -> no grants, ptr stays 5.
- Non-power-of-two: N=6, W=2, ptr=5, req=6'b10_0001 -> slot0 idx5, slot1 idx0, next ptr=1 (never 6 or 7).
- Age boost (RR_SEL_AGE_BOOST_EN, AGE_MAX=3, N=8, W=1): req[7] held high while req bits 0–6 are presented so that rotation never reaches 7 for 3 enabled cycles -> on the 4th enabled cycle slot0=idx7, ptr unchanged, and req[7]'s counter clears to 0.

Source files
------------

// File: rtl/rr_multi_selector.sv
// rr_multi_selector: rotating-priority selector granting up to W of N
// requesters per cycle, searching circularly from a registered pointer.
// Optional feature macro: RR_SEL_AGE_BOOST_EN (per-requester wait counters;
// a requester that has waited AGE_MAX enabled cycles is forced into slot 0).
module rr_multi_selector #(
  parameter int N       = 8,
  parameter int W       = 2,
  parameter int AGE_MAX = 15,
  localparam int IDX_W  = $clog2(N)
) (
  input  logic               clock,
  input  logic               reset_n,
  input  logic               en,
  input  logic [N-1:0]       req,
  output logic [W*N-1:0]     gnt_bus,
  output logic [W*IDX_W-1:0] gnt_idx,
  output logic [W-1:0]       gnt_valid,
  output logic [N-1:0]       gnt_any,
  output logic [IDX_W-1:0]   ptr_out
);

  logic [IDX_W-1:0]   ptr_q, ptr_d;
  logic [W*N-1:0]     busRaw;
  logic [W*IDX_W-1:0] idxRaw;
  logic [W-1:0]       validRaw;
  logic [N-1:0]       anyRaw;
  logic [IDX_W:0]     candSum;
  logic [IDX_W-1:0]   candIdx;
  logic               skipCand;
  int                 slotCnt;

`ifdef RR_SEL_AGE_BOOST_EN
  localparam int AGE_W = $clog2(AGE_MAX + 1);

  logic [AGE_W-1:0] age_q [N];
  logic             boostHit;
  logic [IDX_W-1:0] boostIdx;

  // Find the lowest-index requester whose wait counter has saturated
  always_comb begin
    boostHit = 1'b0;
    boostIdx = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (req[i] && (age_q[i] == AGE_W'(AGE_MAX))) begin
        boostHit = 1'b1;
        boostIdx = IDX_W'(i);
      end
    end
  end

  // Wait counters: count while starved, clear on grant or idle, hold on stall
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < N; i++) age_q[i] <= '0;
    end else if (en) begin
      for (int i = 0; i < N; i++) begin
        if (!req[i] || anyRaw[i]) age_q[i] <= '0;
        else if (age_q[i] != AGE_W'(AGE_MAX)) age_q[i] <= age_q[i] + 1'b1;
      end
    end
  end
`endif

  // Circular search from the pointer filling slots in priority order;
  // the pointer moves just past the last rotation-filled grant
  always_comb begin
    busRaw   = '0;
    idxRaw   = '0;
    validRaw = '0;
    ptr_d    = ptr_q;
    slotCnt  = 0;
    candSum  = '0;
    candIdx  = '0;
    skipCand = 1'b0;
    if (en) begin
`ifdef RR_SEL_AGE_BOOST_EN
      if (boostHit) begin
        busRaw[0 +: N]     = N'(1) << boostIdx;
        idxRaw[0 +: IDX_W] = boostIdx;
        validRaw[0]        = 1'b1;
        slotCnt            = 1;
      end
`endif
      for (int off = 0; off < N; off++) begin
        candSum = {1'b0, ptr_q} + (IDX_W+1)'(off);
        if (candSum >= (IDX_W+1)'(N)) candSum = candSum - (IDX_W+1)'(N);
        candIdx = candSum[IDX_W-1:0];
`ifdef RR_SEL_AGE_BOOST_EN
        skipCand = boostHit && (candIdx == boostIdx);
`else
        skipCand = 1'b0;
`endif
        if (req[candIdx] && !skipCand && (slotCnt < W)) begin
          for (int s = 0; s < W; s++) begin
            if (s == slotCnt) begin
              busRaw[s*N +: N]         = N'(1) << candIdx;
              idxRaw[s*IDX_W +: IDX_W] = candIdx;
              validRaw[s]              = 1'b1;
            end
          end
          slotCnt = slotCnt + 1;
          ptr_d   = (candIdx == IDX_W'(N - 1)) ? '0 : candIdx + 1'b1;
        end
      end
    end
  end

  // Merge all slots into a per-requester grant vector
  always_comb begin
    anyRaw = '0;
    for (int s = 0; s < W; s++) anyRaw = anyRaw | busRaw[s*N +: N];
  end

  // Round-robin pointer register
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) ptr_q <= '0;
    else          ptr_q <= ptr_d;
  end

  assign gnt_bus   = reset_n ? busRaw   : '0;
  assign gnt_idx   = reset_n ? idxRaw   : '0;
  assign gnt_valid = reset_n ? validRaw : '0;
  assign gnt_any   = reset_n ? anyRaw   : '0;
  assign ptr_out   = ptr_q;

  assert property (@(posedge clock) disable iff (!reset_n) (gnt_any & ~req) == '0);
  assert property (@(posedge clock) disable iff (!reset_n) int'(ptr_q) < N);
  assert property (@(posedge clock) disable iff (!reset_n)
                   ((gnt_valid >> 1) & ~gnt_valid) == '0);
  assert property (@(posedge clock) disable iff (!reset_n)
                   en |-> ($countones(gnt_any) == $countones(gnt_valid)) &&
                          ($countones(gnt_valid) ==
                           (($countones(req) < W) ? $countones(req) : W)));

  for (genvar gs = 0; gs < W; gs++) begin : gSlotCheck
    assert property (@(posedge clock) disable iff (!reset_n)
                     $onehot0(gnt_bus[gs*N +: N]));
  end

endmodule
